// File: rtl/opmem_pkg.sv
// opmem_pkg: shared constants, state encoding and requester IDs for the
// op memory arbiter (opmem_arbiter) and its round-robin picker (opmem_rr2).
package opmem_pkg;

    localparam int OPMEM_AW    = 4;
    localparam int OPMEM_DW    = 8;
    localparam int OPMEM_DEPTH = 1 << OPMEM_AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_OREG = 2'd2
    } state_t;

    // Requester IDs double as bit positions in the request/grant vectors
    localparam logic LD = 1'b0;
    localparam logic FE = 1'b1;

endpackage

// File: rtl/opmem_rr2.sv
// opmem_rr2: two-way round-robin picker. A lone requester always wins; on
// a conflict the requester not served last wins. The last-grant register
// only moves when the owner commits a grant (upd) and resets to FE so the
// loader takes the first conflict.
module opmem_rr2
    import opmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt,
    output logic       last_q
);

    logic last_d;

    // One-hot pick from the current requests and the last-grant history
    always_comb begin
        gnt = 2'b00;
        if (req[LD] && req[FE]) begin
            if (last_q == FE) begin
                gnt[LD] = 1'b1;
            end else begin
                gnt[FE] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

    // Record the winner whenever a grant is actually committed
    always_comb begin
        last_d = last_q;
        if (upd && (gnt != 2'b00)) begin
            last_d = gnt[FE] ? FE : LD;
        end
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= FE;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/opmem_arbiter.sv
// opmem_arbiter: shares the single-port op RAM between the program loader
// (writes) and the fetch unit (reads), round-robin on conflicts. Writes
// complete in the grant cycle; reads hold the arbiter busy until the RAM
// data is captured into fe_op, then pulse fe_valid for one cycle.
// Build option: OPMEM_OREG_EN enables the RAM output register (ram_oce=1)
// and adds the RD_OREG state for the extra cycle of read latency.
module opmem_arbiter
    import opmem_pkg::*;
#(
    parameter int AW = OPMEM_AW,
    parameter int DW = OPMEM_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_gnt,
    input  logic          fe_req,
    input  logic [AW-1:0] fe_addr,
    output logic          fe_gnt,
    output logic          fe_valid,
    output logic [DW-1:0] fe_op,
    output logic          busy,
    output logic          ram_ce,
    output logic          ram_wre,
    output logic          ram_oce,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_t        state_q, state_d;
    logic          fe_valid_q, fe_valid_d;
    logic [DW-1:0] fe_op_q, fe_op_d;
    logic          arb_en;
    logic [1:0]    rr_req;
    logic [1:0]    rr_gnt;
    logic          rr_last_unused;

    // Arbitrate only when idle and out of reset, so grants stay low in reset
    assign arb_en = rst && (state_q == IDLE);
    assign rr_req = arb_en ? {fe_req, ld_req} : 2'b00;

    opmem_rr2 u_rr2 (
        .clk    (clk),
        .rst    (rst),
        .req    (rr_req),
        .upd    (arb_en),
        .gnt    (rr_gnt),
        .last_q (rr_last_unused)
    );

`ifdef OPMEM_OREG_EN
    assign ram_oce = 1'b1;
`else
    assign ram_oce = 1'b0;
`endif

    assign fe_valid = fe_valid_q;
    assign fe_op    = fe_op_q;
    assign busy     = (state_q != IDLE);

    // Next state, RAM command and fetch result capture
    always_comb begin
        state_d    = state_q;
        fe_valid_d = 1'b0;
        fe_op_d    = fe_op_q;
        ld_gnt     = 1'b0;
        fe_gnt     = 1'b0;
        ram_ce     = 1'b0;
        ram_wre    = 1'b0;
        ram_ad     = '0;
        ram_din    = '0;
        case (state_q)
            IDLE: begin
                if (rr_gnt[LD]) begin
                    ld_gnt  = 1'b1;
                    ram_ce  = 1'b1;
                    ram_wre = 1'b1;
                    ram_ad  = ld_addr;
                    ram_din = ld_data;
                end else if (rr_gnt[FE]) begin
                    fe_gnt = 1'b1;
                    ram_ce = 1'b1;
                    ram_ad = fe_addr;
`ifdef OPMEM_OREG_EN
                    state_d = RD_OREG;
`else
                    state_d = RD_WAIT;
`endif
                end
            end
`ifdef OPMEM_OREG_EN
            RD_OREG: begin
                // Keep the RAM enabled while its output register loads
                ram_ce  = 1'b1;
                state_d = RD_WAIT;
            end
`endif
            RD_WAIT: begin
                fe_op_d    = ram_dout;
                fe_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered fetch outputs; reset aborts any read in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fe_valid_q <= 1'b0;
            fe_op_q    <= '0;
        end else begin
            state_q    <= state_d;
            fe_valid_q <= fe_valid_d;
            fe_op_q    <= fe_op_d;
        end
    end

endmodule

// File: tb/tb_opmem_arbiter.sv
// Bench for opmem_arbiter: behavioural RAM on the RAM pins, a transaction
// model of the arbiter (memory array, busy countdown, last-winner flag),
// and a scoreboard queue of expected fetch results drained by a monitor.
module tb_opmem_arbiter;
    import opmem_pkg::*;

    localparam int AW = OPMEM_AW;
    localparam int DW = OPMEM_DW;
`ifdef OPMEM_OREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          fe_req = 1'b0;
    logic [AW-1:0] fe_addr = '0;
    logic          ld_gnt, fe_gnt, fe_valid, busy;
    logic [DW-1:0] fe_op;
    logic          ram_ce, ram_wre, ram_oce;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din, ram_dout;

    opmem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_gnt   (ld_gnt),
        .fe_req   (fe_req),
        .fe_addr  (fe_addr),
        .fe_gnt   (fe_gnt),
        .fe_valid (fe_valid),
        .fe_op    (fe_op),
        .busy     (busy),
        .ram_ce   (ram_ce),
        .ram_wre  (ram_wre),
        .ram_oce  (ram_oce),
        .ram_ad   (ram_ad),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM
    logic [DW-1:0] ram_mem [OPMEM_DEPTH];
    logic [DW-1:0] ram_q1, ram_q2;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) ram_mem[ram_ad] <= ram_din;
            else         ram_q1 <= ram_mem[ram_ad];
        end
    end
    always @(posedge clk) if (ram_oce) ram_q2 <= ram_q1;
`ifdef OPMEM_OREG_EN
    assign ram_dout = ram_q2;
`else
    assign ram_dout = ram_q1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard
    typedef struct {
        logic [DW-1:0] op;
        int            due;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [DW-1:0] m_mem [OPMEM_DEPTH];
    int            m_busy = 0;
    bit            m_last_fe = 1'b1;

    // Monitor: every fe_valid must match the oldest outstanding read
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("fe_valid in reset", fe_valid, 1'b0);
        end else if (fe_valid) begin
            if (sb.size() == 0) begin
                chk("fe_valid unexpected", fe_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("fe_valid cycle", cyc, e.due);
                chk("fe_op", fe_op, e.op);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("fe_valid missing", fe_valid, 1'b1);
            e = sb.pop_front();
        end
    end

    // One clock of stimulus with grant prediction and model update
    task automatic step(input logic lr, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                        input logic fr, input logic [AW-1:0] fa,
                        output bit g_ld, output bit g_fe, output bit o_ld, output bit o_fe);
        @(negedge clk);
        #2;
        ld_req = lr; ld_addr = la; ld_data = ldd; fe_req = fr; fe_addr = fa;
        #1;
        g_ld = 1'b0;
        g_fe = 1'b0;
        if (rst && m_busy == 0) begin
            if (lr && fr) begin
                if (m_last_fe) g_ld = 1'b1;
                else           g_fe = 1'b1;
            end else if (lr) begin
                g_ld = 1'b1;
            end else if (fr) begin
                g_fe = 1'b1;
            end
        end
        chk("ld_gnt", ld_gnt, g_ld);
        chk("fe_gnt", fe_gnt, g_fe);
        chk("busy", busy, m_busy != 0);
        o_ld = ld_gnt;
        o_fe = fe_gnt;
        if (g_fe) sb.push_back('{op: m_mem[int'(fa) % OPMEM_DEPTH], due: cyc + LAT});
        @(posedge clk);
        if (m_busy > 0) m_busy--;
        if (g_ld) begin
            m_mem[la] = ldd;
            m_last_fe = 1'b0;
        end
        if (g_fe) begin
            m_busy    = LAT - 1;
            m_last_fe = 1'b1;
        end
    endtask

    task automatic idle_step();
        bit a, b, c, d;
        step(1'b0, '0, '0, 1'b0, '0, a, b, c, d);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit gl, gf, ol, of, got;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            step(1'b1, a, d, 1'b0, '0, gl, gf, ol, of);
            got = ol;
        end
        chk("write granted", got, 1'b1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit gl, gf, ol, of, got;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            step(1'b0, '0, '0, 1'b1, a, gl, gf, ol, of);
            got = of;
        end
        chk("read granted", got, 1'b1);
    endtask

    // Hold reset for n cycles with both requesters asserting
    task automatic hold_reset(input int n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        m_busy    = 0;
        m_last_fe = 1'b1;
        ld_req = 1'b1;
        fe_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            chk("rst ld_gnt", ld_gnt, 1'b0);
            chk("rst fe_gnt", fe_gnt, 1'b0);
            chk("rst busy", busy, 1'b0);
            chk("rst fe_op", fe_op, 8'h00);
            @(negedge clk);
            #2;
        end
        rst = 1'b1;
        ld_req = 1'b0;
        fe_req = 1'b0;
    endtask

    initial begin
        bit gl, gf, ol, of, lp, fp;
        int ngr;
        logic [AW-1:0] la, fa;
        logic [DW-1:0] ldd;
        logic [4:0] wide;

        hold_reset(3);

        // Burst writes then full readback
        for (int i = 0; i < OPMEM_DEPTH; i++) begin
            step(1'b1, AW'(i), DW'(8'h10 + i), 1'b0, '0, gl, gf, ol, of);
            chk("burst ld_gnt", ol, 1'b1);
        end
        for (int i = 0; i < OPMEM_DEPTH; i++) do_read(AW'(i));

        // Write then back-to-back read of the same address
        do_write(4'd3, 8'hA5);
        do_read(4'd3);

        // Write arriving during a read is held off; read returns old data
        do_read(4'd5);
        step(1'b1, 4'd5, 8'hEE, 1'b0, '0, gl, gf, ol, of);
        chk("ld_gnt while busy", ol, 1'b0);
        do_write(4'd5, 8'hEE);
        do_read(4'd5);

        // Address wrap
        do_write(4'd3, 8'h3C);
        wide = 5'h13;
        do_read(wide[AW-1:0]);

        // Reset in the middle of a read
        do_read(4'd7);
        for (int k = 0; k < LAT - 2; k++) idle_step();
        hold_reset(3);

        // Conflict fairness from reset: loader, fetch, loader, fetch...
        ngr = 0;
        for (int k = 0; k < 60 && ngr < 20; k++) begin
            la  = AW'($urandom);
            fa  = AW'($urandom);
            ldd = DW'($urandom);
            step(1'b1, la, ldd, 1'b1, fa, gl, gf, ol, of);
            if (ol || of) begin
                chk("rr order fe", of, (ngr % 2) == 1);
                chk("rr order ld", ol, (ngr % 2) == 0);
                ngr++;
            end
        end
        chk("fairness grant count", ngr, 20);

        // Random traffic with requests held until granted
        lp = 1'b0; fp = 1'b0; la = '0; fa = '0; ldd = '0;
        for (int k = 0; k < 300; k++) begin
            if (!lp && $urandom_range(0, 1) == 1) begin
                lp  = 1'b1;
                la  = AW'($urandom);
                ldd = DW'($urandom);
            end
            if (!fp && $urandom_range(0, 2) == 0) begin
                fp = 1'b1;
                fa = AW'($urandom);
            end
            step(lp, la, ldd, fp, fa, gl, gf, ol, of);
            if (gl) lp = 1'b0;
            if (gf) fp = 1'b0;
        end

        for (int k = 0; k < LAT + 2; k++) idle_step();
        chk("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/opmem_arbiter.md
# opmem_arbiter

Two-requester arbiter and sequencer for the single-port op memory (opram, 16 × 8-bit). It shares the RAM between the program loader, which writes ops, and the core's fetch unit, which reads ops. Both requesters are served with round-robin fairness. The block handles the RAM's synchronous read latency and presents the fetched op as a registered, single-cycle-valid result. It replaces direct wiring of the loader or fetch signals onto the RAM pins.

## Interface
- AW, 4, RAM address width (depth 2^AW)
- DW, 8, op width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ld_req  in  1  loader write request, held until granted
- ld_addr  in  AW  loader write address
- ld_data  in  DW  loader write data
- ld_gnt  out  1  write accepted this cycle
- fe_req  in  1  fetch read request, held until granted
- fe_addr  in  AW  fetch read address
- fe_gnt  out  1  read accepted this cycle
- fe_valid  out  1  one-cycle pulse, fe_op holds new read data
- fe_op  out  DW  last fetched op, registered, stable until next fe_valid
- busy  out  1  read in flight (state ≠ IDLE)
- ram_ce, ram_wre, ram_oce  out  1  RAM enables
- ram_ad  out  AW; ram_din  out  DW; ram_dout  in  DW  RAM port

## Operation
- **States:** IDLE, RD_WAIT, RD_OREG (RD_OREG exists only with OPMEM_OREG_EN).
- **IDLE, single requester:** grant it combinationally and drive its command onto the RAM pins in the same cycle.
- **IDLE, both requesting:** grant the requester not granted last. The last-grant flag resets to "fetch", so the loader wins the first conflict.
- **Write grant:**
  - Drive ram_ce=1, ram_wre=1, ram_ad=ld_addr, ram_din=ld_data, and ld_gnt=1.
  - Stay in IDLE, so back-to-back writes at 1/cycle are allowed.
- **Read grant:**
  - Drive ram_ce=1, ram_wre=0, ram_ad=fe_addr, and fe_gnt=1.
  - Go to RD_WAIT, or to RD_OREG when the macro is on.
- **RD_OREG:** ram_ce=1; go to RD_WAIT.
- **RD_WAIT:**
  - Capture ram_dout into fe_op.
  - Pulse fe_valid on the next cycle.
  - Return to IDLE.
- **No new grants while busy:** requests arriving while busy are held by the requester and arbitrated on return to IDLE.
- **Defaults:** ram_ce=0 and ram_wre=0 when no command is issued. ram_ad and ram_din are don't-care when ram_ce=0 and are driven to 0.
- **Read-after-write** to the same address, back-to-back, returns the new data, because the RAM write completes before the read is issued.
- **Addresses** wrap naturally at AW bits. No range check is performed.

## Timing
- **Reset values:** state=IDLE, fe_valid=0, fe_op=0x00, busy=0, ld_gnt=0, fe_gnt=0, ram_ce=0, ram_wre=0, last-grant=fetch.
- **Grants during reset:** grants are forced low while rst=0.
- **Read latency, fe_gnt at cycle N:** fe_valid at N+2 (macro off) or N+3 (macro on).
- **Write latency:** the RAM is updated at the clock edge ending the ld_gnt cycle.
- **Minimum read-to-read spacing:** 2 cycles (macro off) or 3 cycles (macro on). The next fe_gnt can coincide with fe_valid.
- **Reset asserted mid-read:** abort the read and return to IDLE. fe_valid is never pulsed for the aborted read, and fe_op returns to 0x00.
- **fe_valid timing:** fe_valid is a registered output and never fires in the same cycle as a grant for the same request.

## Configuration
- **OPMEM_OREG_EN defined:**
  - ram_oce=1, tied high.
  - Insert RD_OREG, giving 2-cycle RAM read latency.
- **OPMEM_OREG_EN undefined:**
  - ram_oce=0, bypass mode.
  - Read latency is 1 cycle and RD_OREG is not synthesized.

## Structure
- **Shared package (opmem_pkg):**
  - AW, DW, and opmem depth constants.
  - State encoding: IDLE=2'd0, RD_WAIT=2'd1, RD_OREG=2'd2.
  - Requester IDs LD=1'b0, FE=1'b1.
- **Sub-module opmem_rr2:** 2-way round-robin picker with inputs req[1:0] and update enable, and outputs a one-hot grant and the last-grant register. The FSM and datapath stay in opmem_arbiter.

## Test plan
- **Reset:** assert rst=0 mid-read (during RD_WAIT) -> fe_valid never pulses; fe_op=0x00; busy=0; grants low until rst=1.
- **Single write then read:** ld_req with addr 3, data 0xA5, then fe_req at addr 3 -> ld_gnt 1 cycle; fe_valid at gnt+2 (+3 with OPMEM_OREG_EN) with fe_op=0xA5.
- **Conflict fairness:** ld_req and fe_req held high continuously from reset -> grants go loader, fetch, loader, fetch…; no requester is starved over 20 grants.
- **Burst writes:** 16 consecutive ld_req to addresses 0..15 with data 0x10+addr -> 16 ld_gnt on consecutive cycles; readback of addresses 0..15 returns 0x10..0x1F.
- **Busy blocking:** ld_req arrives in the cycle after fe_gnt -> ld_gnt withheld until state=IDLE; the write then lands and the in-flight read returns the old data.
- **Address wrap:** fe_addr driven as 5'h13 truncated to AW=4 -> reads address 3.
